// File: rtl/ifm_skew_fetch_if.sv
// Bus bundle between the IFM read-side fetch controller, its command source,
// the banked port-B RAM read path and the systolic-array row inputs.
interface ifm_skew_fetch_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BANKS  = 16,
    parameter int LEN_WIDTH  = 16
);
    logic                            start;
    logic [ADDR_WIDTH-1:0]           base_addr;
    logic [LEN_WIDTH-1:0]            num_rows;
    logic                            busy;
    logic                            done;
    logic                            rd_en;
    logic [NUM_BANKS*ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH*NUM_BANKS-1:0] rd_data;
    logic [DATA_WIDTH*NUM_BANKS-1:0] out_data;
    logic [NUM_BANKS-1:0]            out_valid;

    // Command source / RAM model side
    modport master (
        output start, base_addr, num_rows, rd_data,
        input  busy, done, rd_en, rd_addr, out_data, out_valid
    );

    // Fetch controller side
    modport slave (
        input  start, base_addr, num_rows, rd_data,
        output busy, done, rd_en, rd_addr, out_data, out_valid
    );
endinterface

// File: rtl/ifm_skew_fetch.sv
// Read-side controller for the banked IFM RAM: fetches num_rows vectors from
// consecutive addresses and feeds them to the systolic array with a diagonal
// skew (lane i delayed i extra cycles). Lanes without data are driven to zero.
module ifm_skew_fetch #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BANKS  = 16,
    parameter int LEN_WIDTH  = 16
) (
    input logic             clk,
    input logic             rst,
    ifm_skew_fetch_if.slave bus
);

    localparam int DRAIN_W = $clog2(NUM_BANKS + 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  row_cnt;
    logic [LEN_WIDTH-1:0]  last_row;
    logic [DRAIN_W-1:0]    drain_cnt;
    logic                  busy_q;
    logic                  done_q;
    logic                  rd_en_q;
    logic                  rd_valid;

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.rd_en = rd_en_q;

    // Command FSM: accept a command in IDLE, issue one read per cycle, then wait
    // for the slowest lane to empty before signalling completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            row_cnt   <= '0;
            last_row  <= '0;
            drain_cnt <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.num_rows != '0) begin
                            state    <= FETCH;
                            busy_q   <= 1'b1;
                            rd_en_q  <= 1'b1;
                            addr_q   <= bus.base_addr;
                            row_cnt  <= '0;
                            last_row <= bus.num_rows - LEN_WIDTH'(1);
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (row_cnt == last_row) begin
                        state     <= DRAIN;
                        rd_en_q   <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        row_cnt <= row_cnt + LEN_WIDTH'(1);
                        addr_q  <= addr_q + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    // One cycle of RAM latency, one capture stage, and
                    // NUM_BANKS-1 skew stages on the last lane
                    if (drain_cnt == DRAIN_W'(NUM_BANKS)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Port-B data arrives one cycle after its address, so the read strobe
    // delayed by one cycle marks which rd_data words belong to the command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en_q;
        end
    end

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] d_pipe [0:i];
        logic                  v_pipe [0:i];

        assign bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = addr_q;
        assign bus.out_data[i*DATA_WIDTH +: DATA_WIDTH] = d_pipe[i];
        assign bus.out_valid[i] = v_pipe[i];

        // Capture stage zeroes invalid words, then i skew stages carry data
        // and valid together so padding lanes stay at zero
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= i; j++) begin
                    d_pipe[j] <= '0;
                    v_pipe[j] <= 1'b0;
                end
            end else begin
                d_pipe[0] <= rd_valid ? bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                v_pipe[0] <= rd_valid;
                for (int j = 1; j <= i; j++) begin
                    d_pipe[j] <= d_pipe[j-1];
                    v_pipe[j] <= v_pipe[j-1];
                end
            end
        end
    end

endmodule

// File: doc/ifm_skew_fetch.md
Name: ifm_skew_fetch

Overview:
- Read-side controller for the banked IFM dual-port RAM.
- On a start command, issues one vector read per cycle, presenting the same address to all NUM_BANKS banks on port B.
- Captures the registered RAM data and applies a diagonal skew (lane i delayed i extra cycles) so the result can drive the systolic-array row inputs directly.
- Lanes without valid data are forced to zero, giving the systolic array its zero padding.

Parameters:
- ADDR_WIDTH, 19, per-bank address width.
- DATA_WIDTH, 8, bits per bank element.
- NUM_BANKS, 16, number of banks / array rows.
- LEN_WIDTH, 16, width of the row-count command.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  command strobe; sampled only when busy=0.
- base_addr  input  ADDR_WIDTH  first vector address; latched on start.
- num_rows  input  LEN_WIDTH  number of vectors to fetch; latched on start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle completion pulse.
- rd_en  output  1  port-B read strobe (informational; the RAM reads every cycle).
- rd_addr  output  NUM_BANKS*ADDR_WIDTH  per-bank address, all lanes equal; lane i is bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  input  DATA_WIDTH*NUM_BANKS  port-B dout; valid one cycle after its address.
- out_data  output  DATA_WIDTH*NUM_BANKS  skewed lanes to the systolic array.
- out_valid  output  NUM_BANKS  per-lane valid.

Behaviour:
- Reset (async, active-high): state IDLE; counters, skew registers, busy, done, rd_en, rd_addr, out_data and out_valid all 0. In-flight RAM data is discarded.
- FSM states:
  - IDLE: start=1 with num_rows!=0 latches the command and moves to FETCH. start=1 with num_rows==0 raises done in the next cycle, issues no reads and stays in IDLE.
  - FETCH: exactly num_rows consecutive cycles with rd_en=1. In the k-th FETCH cycle (k=0..N-1), rd_addr = base_addr + k, modulo 2^ADDR_WIDTH. No range check against RAM depth. After the last read, move to DRAIN.
  - DRAIN: rd_en=0 and rd_addr holds its last value. Wait until lane NUM_BANKS-1 has emitted its last element, then return to IDLE with done=1 for one cycle.
- Timing, with start sampled at edge of cycle 0 and N = num_rows:
  - rd_en=1 in cycles 1..N, address base+k in cycle 1+k.
  - rd_data for row k is present in cycle 2+k and is registered.
  - out_valid[i]=1 with out_data lane i = row k, lane i, in cycle 3+k+i.
  - done=1 and busy=0 in cycle N+2+NUM_BANKS (=N+18 at default).
  - busy=1 in cycles 1..N+17.
- Skew: lane i is a delay line of i registers after the common capture register; lane 0 has none. Valid bits travel with the data.
- Lanes with out_valid[i]=0 drive out_data lane i = 0.
- start while busy=1 is ignored. start in the done cycle (busy=0) is accepted, with rd_en=1 in the next cycle.
- Back-to-back commands may overlap their skew drain with the next fetch only via that done-cycle restart; there is no other pipelining of commands.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst for 3 cycles mid-random stimulus -> all outputs 0 immediately (async); busy=0, out_valid=0.
- Basic fetch, N=4, base_addr=100, RAM model returns lane i = (addr+i)&0xFF:
  - rd_en cycles 1-4, addresses 100..103.
  - out_valid[i] cycles 3+i..6+i, with lane i data = (100+k+i)&0xFF.
  - done at cycle 22, busy cycles 1-21.
- Zero length, num_rows=0 -> done=1 at cycle 1, rd_en never high, busy stays 0.
- Wrap-around, base_addr=524286, N=4 -> rd_addr sequence 524286, 524287, 0, 1 on all 16 lanes.
- Command collision: start pulsed at cycle 5 of a busy run is ignored (same cycle count). start asserted in the done cycle -> rd_en=1 the following cycle with the new base.
- Reset mid-DRAIN, rst at cycle 10 of the N=4 run -> out_valid and out_data 0 at once, no done pulse. A subsequent start with N=1, base=7 completes normally with done at cycle 19.
